skew_fifo_in: RTL and testbench
===============================

SKEW_FIFO_IN -- requirements
Module: skew_fifo_in

Interface
- REQ-001 The block SHALL have parameter SA_SIZE, default 8: number of systolic-array rows (>=2).
- REQ-002 The block SHALL have parameter ACTIVATION_SIZE, default 32: activation width in bits.
- REQ-003 The block SHALL have parameter DEPTH, default 4: per-row queue entries (power of 2, >=2).
- REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
- REQ-005 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
- REQ-006 The block SHALL have port in_valid, input, 1 bit: write request.
- REQ-007 The block SHALL have port in_ready, output, 1 bit: write accepted when in_valid is also high.
- REQ-008 The block SHALL have port in, input, ACTIVATION_SIZE bits: write data.
- REQ-009 The block SHALL have port in_row_idx, input, $clog2(SA_SIZE) bits: target row queue.
- REQ-010 The block SHALL have port stream_en, input, 1 bit: permit wavefront issue.
- REQ-011 The block SHALL have port clear, input, 1 bit: synchronous flush.
- REQ-012 The block SHALL have port outputs, output, SA_SIZE x ACTIVATION_SIZE bits: skewed row data to the array.
- REQ-013 The block SHALL have port out_valid, output, SA_SIZE bits: per-row qualifier for outputs.
- REQ-014 The block SHALL have port wave_avail, output, 1 bit: all row queues non-empty.
- REQ-015 The block SHALL have port all_empty, output, 1 bit: all queues empty and no valid in the skew pipeline.

Function
- REQ-016 The block SHALL keep one DEPTH-entry FIFO per row, with read/write pointers wrapping modulo DEPTH and a count of 0..DEPTH.
- REQ-017 in_ready SHALL equal (count[in_row_idx] != DEPTH) && !clear; it SHALL NOT depend on stream_en.
- REQ-018 A push (in_valid && in_ready) SHALL write in to the tail of queue in_row_idx; in_valid with in_ready low SHALL leave all state unchanged.
- REQ-019 wave_avail SHALL equal AND over rows of (count[r] != 0), evaluated on registered counts.
- REQ-020 A wavefront fire SHALL occur when stream_en && wave_avail && !clear; it SHALL pop the head of every row queue in the same cycle.
- REQ-021 Row r SHALL own a skew pipeline of r+1 stages (data plus valid bit) that advances every cycle unconditionally; stage 0 SHALL load the popped head with valid=1 on fire, and data held / valid=0 otherwise.
- REQ-022 outputs[r]/out_valid[r] SHALL be the last stage of row r, so a wavefront fired in cycle t appears at row r in cycle t+1+r, with exactly one valid cycle per row.
- REQ-023 When out_valid[r]=0, outputs[r] SHALL hold its previous value.
- REQ-024 A simultaneous push and pop on the same row SHALL leave count unchanged, and a full row SHALL still refuse the push (REQ-017).
- REQ-025 A push into an empty row SHALL NOT be poppable in the same cycle; it becomes poppable from the next cycle.
- REQ-026 Partial wavefronts SHALL never issue: if any row is empty, no row pops and bubbles (valid=0) enter stage 0.
- REQ-027 clear SHALL, at the next edge, zero all pointers, counts and skew valid bits; skew data SHALL be retained and pushes/fires in that cycle SHALL be ignored.
- REQ-028 all_empty SHALL be 1 iff every count is 0 and every skew valid bit is 0.

Reset
- REQ-029 While resetn=0, the block SHALL asynchronously zero all pointers, counts, skew data and valid bits, so outputs=0, out_valid=0, wave_avail=0, in_ready=1 and all_empty=1.
- REQ-030 Reset deassertion SHALL be synchronised externally; the block SHALL be operational on the first rising edge with resetn=1.
- REQ-031 Reset asserted mid-stream SHALL discard queued and in-flight wavefronts without emitting partial data.

Verification (SA_SIZE=4, DEPTH=2, ACTIVATION_SIZE=32)
- Push rows 0..3 values 0x10..0x13, pulse stream_en 1 cycle (t) -> out_valid[r]=1 only at cycle t+1+r, with outputs[r]=0x10+r; then all_empty=1.
- Push 2 entries to row 1, present a third -> in_ready=0 while in_row_idx=1; count stays 2; push to row 2 is still accepted.
- Rows 0,1,3 filled, row 2 empty, stream_en=1 for 5 cycles -> no out_valid asserted; push row 2 -> wavefront issues the next cycle.
- Row 0 full (2), other rows non-empty, fire plus push row 0 in the same cycle -> pop OK, push refused (in_ready=0), row 0 count=1 after.
- Two back-to-back wavefronts A=0xA0+r, B=0xB0+r -> row 3 shows A at t+4 and B at t+5, each valid for one cycle.
- Queues loaded and a wavefront in flight, then resetn=0 for 1 cycle mid-cycle -> outputs/out_valid go to 0 immediately; no later valid appears without new pushes.

Source files
------------

// File: rtl/skew_fifo_in.sv
// skew_fifo_in: per-row activation FIFOs that issue whole wavefronts into a
// row-skewed pipeline feeding a systolic array (row r delayed by r cycles).
module skew_fifo_in #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32,
  parameter int DEPTH           = 4
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [ACTIVATION_SIZE-1:0]              in,
  input  logic [$clog2(SA_SIZE)-1:0]              in_row_idx,
  input  logic                                    stream_en,
  input  logic                                    clear,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] outputs,
  output logic [SA_SIZE-1:0]                      out_valid,
  output logic                                    wave_avail,
  output logic                                    all_empty
);
  localparam int RW = $clog2(SA_SIZE);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [SA_SIZE-1:0] w_nz, w_full, w_busy;
  logic               w_fire;
  assign in_ready   = !w_full[in_row_idx] && !clear;
  assign wave_avail = &w_nz;
  assign w_fire     = stream_en && wave_avail && !clear;
  assign all_empty  = !(|w_nz) && !(|w_busy);
  for (genvar r = 0; r < SA_SIZE; r++) begin : g_row
    localparam int N = r + 1;
    logic [PW-1:0]              r_wptr, r_rptr;
    logic [CW-1:0]              r_cnt;
    logic [ACTIVATION_SIZE-1:0] r_mem [DEPTH];
    logic [ACTIVATION_SIZE-1:0] r_sd [N];
    logic [N-1:0]               r_sv;
    logic                       w_push;
    assign w_push = in_valid && in_ready && (in_row_idx == RW'(r));
    always_ff @(posedge clk) if (w_push) r_mem[r_wptr] <= in;
    // Stage data only moves alongside a valid bit, so outputs hold between wavefronts
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_sv   <= '0;
        for (int k = 0; k < N; k++) r_sd[k] <= '0;
      end else if (clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_sv   <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_fire) r_rptr <= r_rptr + 1'b1;
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_fire);
        r_sv  <= (r_sv << 1) | N'(w_fire);
        if (w_fire) r_sd[0] <= r_mem[r_rptr];
        for (int k = 1; k < N; k++) if (r_sv[k-1]) r_sd[k] <= r_sd[k-1];
      end
    end
    assign w_nz[r]      = r_cnt != '0;
    assign w_full[r]    = r_cnt == CW'(DEPTH);
    assign w_busy[r]    = |r_sv;
    assign outputs[r]   = r_sd[N-1];
    assign out_valid[r] = r_sv[N-1];
  end
endmodule

// File: tb/tb_skew_fifo_in.sv
// tb_skew_fifo_in: directed stimulus with a queue-based reference model and
// per-row scoreboards of expected (data, arrival cycle) pairs.
module tb_skew_fifo_in;
  localparam int SA = 4;
  localparam int A  = 32;
  localparam int D  = 2;
  logic              clk = 0, resetn = 0, in_valid = 0, stream_en = 0, clear = 0;
  logic [A-1:0]      din = '0;
  logic [1:0]        idx = '0;
  logic              in_ready, wave_avail, all_empty;
  logic [SA-1:0][A-1:0] outputs;
  logic [SA-1:0]     out_valid;
  typedef struct {logic [A-1:0] d; int c;} exp_t;
  logic [A-1:0] mq [SA][$];
  exp_t         eq [SA][$];
  logic [A-1:0] mlast [SA];
  int cyc = 0, checks = 0, failures = 0;

  skew_fifo_in #(.SA_SIZE(SA), .ACTIVATION_SIZE(A), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in(din), .in_row_idx(idx), .stream_en(stream_en), .clear(clear),
    .outputs(outputs), .out_valid(out_valid), .wave_avail(wave_avail),
    .all_empty(all_empty));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < SA; r++) begin
      mq[r].delete();
      eq[r].delete();
    end
  endtask

  task automatic step();
    bit rdy, av, fire, push, emp;
    exp_t e;
    #1;
    av = 1;
    emp = 1;
    for (int r = 0; r < SA; r++) begin
      if (mq[r].size() == 0) av = 0;
      if (mq[r].size() != 0 || eq[r].size() != 0) emp = 0;
    end
    rdy  = mq[idx].size() != D && !clear;
    fire = stream_en && av && !clear;
    push = in_valid && rdy;
    chk("in_ready", in_ready, rdy);
    chk("wave_avail", wave_avail, av);
    chk("all_empty", all_empty, emp);
    @(posedge clk);
    #1;
    if (clear) model_clear();
    else begin
      if (fire)
        for (int r = 0; r < SA; r++) begin
          e.d = mq[r].pop_front();
          e.c = cyc + r;
          eq[r].push_back(e);
        end
      if (push) mq[idx].push_back(din);
    end
  endtask

  task automatic drv(bit v, int i, logic [A-1:0] d, bit se, bit cl);
    in_valid  = v;
    idx       = i[1:0];
    din       = d;
    stream_en = se;
    clear     = cl;
    step();
  endtask

  always @(negedge clk)
    if (resetn)
      for (int r = 0; r < SA; r++) begin
        bit   due;
        exp_t e;
        due = eq[r].size() > 0 && eq[r][0].c == cyc;
        chk($sformatf("out_valid[%0d]@%0d", r, cyc), out_valid[r], due);
        if (due) begin
          e = eq[r].pop_front();
          mlast[r] = e.d;
        end
        chk($sformatf("outputs[%0d]@%0d", r, cyc), outputs[r], mlast[r]);
      end

  initial begin
    for (int r = 0; r < SA; r++) mlast[r] = '0;
    #1;
    chk("rst_outputs", outputs, '0);
    chk("rst_out_valid", out_valid, '0);
    chk("rst_wave_avail", wave_avail, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_all_empty", all_empty, 1);
    @(posedge clk);
    #1 resetn = 1;
    // single wavefront
    for (int r = 0; r < SA; r++) drv(1, r, 32'h10 + r, 0, 0);
    drv(0, 0, 0, 1, 0);
    repeat (6) drv(0, 0, 0, 0, 0);
    // full row refuses, other rows still accept
    drv(1, 1, 32'h21, 0, 0);
    drv(1, 1, 32'h22, 0, 0);
    drv(1, 1, 32'h23, 0, 0);
    drv(1, 2, 32'h30, 0, 0);
    drv(0, 0, 0, 0, 1);
    // one empty row blocks issue until it is filled
    drv(1, 0, 32'h40, 0, 0);
    drv(1, 1, 32'h41, 0, 0);
    drv(1, 3, 32'h43, 0, 0);
    repeat (5) drv(0, 0, 0, 1, 0);
    drv(1, 2, 32'h42, 1, 0);
    repeat (6) drv(0, 0, 0, 1, 0);
    // fire with a simultaneous push into a full row
    drv(1, 0, 32'h50, 0, 0);
    drv(1, 0, 32'h51, 0, 0);
    for (int r = 1; r < SA; r++) drv(1, r, 32'h50 + r, 0, 0);
    drv(1, 0, 32'h5f, 1, 0);
    drv(1, 0, 32'h53, 0, 0);
    drv(1, 0, 32'h54, 0, 0);
    repeat (5) drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1);
    // back-to-back wavefronts
    for (int r = 0; r < SA; r++) drv(1, r, 32'hA0 + r, 0, 0);
    for (int r = 0; r < SA; r++) drv(1, r, 32'hB0 + r, 0, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 1, 0);
    repeat (6) drv(0, 0, 0, 0, 0);
    // asynchronous reset with a wavefront in flight and data queued
    for (int r = 0; r < SA; r++) drv(1, r, 32'hC0 + r, 0, 0);
    for (int r = 0; r < SA; r++) drv(1, r, 32'hD0 + r, 0, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0);
    #2 resetn = 0;
    #1;
    chk("midrst_outputs", outputs, '0);
    chk("midrst_out_valid", out_valid, '0);
    chk("midrst_all_empty", all_empty, 1);
    chk("midrst_wave_avail", wave_avail, 0);
    chk("midrst_in_ready", in_ready, 1);
    model_clear();
    for (int r = 0; r < SA; r++) mlast[r] = '0;
    @(posedge clk);
    #1 resetn = 1;
    repeat (6) drv(0, 0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
